ir_err_compute: RTL and testbench
=================================

// Module: ir_err_compute
// PURPOSE
//  Stage directly upstream of the PID steering block. Sequences the 8 IR line sensors through the shared A2D
//  (strt_cnv/cnv_cmplt handshake) and forms a signed, position-weighted sum per frame. Publishes that sum as
//  error[15:0] with a 1-cycle err_vld, and publishes line_present; these feed PID's error/err_vld/line_present.
// PARAMETERS
//  FAST_SIM       0        1: both timers run 64x shorter (FRAME_CYCLES/64, SETTLE_CYCLES/64)
//  FRAME_CYCLES   50000    idle cycles from end of one frame to start of next
//  SETTLE_CYCLES  4096     cycles IR_en is high before the first conversion
//  LINE_THRESH    12'h400  any reading > this => line_present
// PORTS
//  clk           in   1   system clock
//  rst           in   1   reset: synchronous, active-high
//  go            in   1   enable; low aborts and idles the block
//  cnv_cmplt     in   1   A2D 1-cycle pulse; res valid in that cycle
//  res           in   12  A2D result, unsigned; larger = more line under sensor
//  strt_cnv      out  1   1-cycle conversion request
//  chnnl         out  3   A2D channel = sensor index 0(left-most)..7(right-most)
//  IR_en         out  1   IR emitter enable
//  error         out  16  signed weighted position error, saturated
//  err_vld       out  1   1-cycle pulse, new error/line_present
//  line_present  out  1   any sensor above LINE_THRESH in last frame
// BEHAVIOUR
//  Reset: all outputs 0; acc=0; state IDLE; timer=0.
//  FSM: IDLE -> (go) SETTLE -> CONV -> WAIT_CMPLT -> {CONV | DONE} -> WAIT_FRAME -> SETTLE ...
//   IDLE: acc, idx, any-flag cleared. SETTLE: IR_en=1; count SETTLE_CYCLES, then CONV.
//   CONV: strt_cnv=1 for exactly this one cycle, chnnl=idx -> WAIT_CMPLT.
//   WAIT_CMPLT: wait unbounded; chnnl held at idx, no further strt_cnv. On cnv_cmplt:
//    acc += W[idx]*res; any |= (res>LINE_THRESH); idx 7 -> DONE, else idx++ -> CONV.
//   DONE (1 cycle): IR_en=0; error<=sat16(acc); line_present<=any; err_vld=1 next cycle.
//   WAIT_FRAME: count FRAME_CYCLES, clear acc/idx/any, then SETTLE.
//  IR_en high from SETTLE entry until the cycle 8th cnv_cmplt is sampled; low otherwise.
//  Latency: err_vld high exactly 2 cycles after the cycle the 8th cnv_cmplt is sampled, for 1 cycle.
//  Weights W[0..7] = -8,-4,-2,-1,+1,+2,+4,+8 (shifts only, no multiplier). acc is 18-bit signed.
//   |acc| max = 15*4095 = 61425.
//  sat16: acc > 32767 -> 16'h7FFF; acc < -32768 -> 16'h8000; else acc[15:0].
//  error/line_present hold between frames, and hold when go falls.
//  go low in any state: next cycle IDLE, IR_en=0, strt_cnv=0, no err_vld. A pending cnv_cmplt is ignored.
//  go re-high: fresh frame from SETTLE, acc cleared.
//  strt_cnv and cnv_cmplt in the same cycle cannot occur; cnv_cmplt outside WAIT_CMPLT is ignored.
//  rst wins over go; rst mid-frame returns all to reset values next edge.
// STRUCTURE
//  Package ir_err_pkg: state enum typedef; weight table constant; ACC_W=18, ERR_W=16;
//   FAST_SIM timer divisor constant 64.
//  Sub-module ir_frame_timer: loadable down-counter shared by SETTLE and WAIT_FRAME, with expire output.
//  FSM, accumulator and saturation stay in ir_err_compute.
// TESTING
//  1 Reset: rst=1 two cycles mid-frame -> all outputs 0, state IDLE, no strt_cnv until go and SETTLE elapse.
//  2 Balanced: all res=12'h800 -> error=16'h0000, line_present=1, one err_vld per frame.
//  3 Single sensor: res[7]=12'h100, others 0 -> error=16'h0800, line_present=0;
//    res[0]=12'h100 only -> 16'hF800.
//  4 Saturation: res[4..7]=12'hFFF, res[0..3]=0 -> error=16'h7FFF; mirrored -> 16'h8000.
//  5 Stall/handshake: cnv_cmplt delayed 100 cycles per channel -> 8 strt_cnv pulses on chnnl 0..7 in order,
//    chnnl stable while waiting, err_vld 2 cycles after 8th cnv_cmplt.
//  6 Abort: go low after 3rd cnv_cmplt -> IR_en=0 next cycle, no err_vld, error unchanged;
//    go high -> first strt_cnv on chnnl 0 after SETTLE.

Source files
------------

// File: rtl/ir_err_pkg.sv
// Shared types and constants for the IR line-sensor error stage.
// Weights are stored as shift amounts; sensor index bit 2 selects the sign.
package ir_err_pkg;

    localparam int unsigned ACC_W        = 18;
    localparam int unsigned ERR_W        = 16;
    localparam int unsigned RES_W        = 12;
    localparam int unsigned TIMER_W      = 16;
    localparam int unsigned FAST_SIM_DIV = 64;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StSettle = 3'd1;
    localparam state_t StConv   = 3'd2;
    localparam state_t StWait   = 3'd3;
    localparam state_t StDone   = 3'd4;
    localparam state_t StFrame  = 3'd5;

    // |W| = 8,4,2,1,1,2,4,8 for sensors 0..7 (symmetric, so index order is moot)
    localparam logic [7:0][1:0] WEIGHT_SHIFT = {2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

    function automatic logic signed [ACC_W-1:0] weighted(input logic [2:0]       idx,
                                                         input logic [RES_W-1:0] res);
        logic signed [ACC_W-1:0] mag;
        mag = {{(ACC_W-RES_W){1'b0}}, res} << WEIGHT_SHIFT[idx];
        return idx[2] ? mag : -mag;
    endfunction

    function automatic logic [ERR_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
        if (acc > 18'sd32767) begin
            return 16'h7FFF;
        end else if (acc < -18'sd32768) begin
            return 16'h8000;
        end
        return acc[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/ir_frame_timer.sv
// Loadable down-counter shared by the settle and inter-frame delays.
// expire_o is high while the count sits at zero.
module ir_frame_timer
    import ir_err_pkg::*;
#(
    parameter int unsigned W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/ir_err_compute.sv
// Sequences the 8 IR sensors through the A2D and publishes a saturated, position-weighted
// error per frame plus a line-present flag for the PID stage.
module ir_err_compute
    import ir_err_pkg::*;
#(
    parameter bit          FAST_SIM      = 1'b0,
    parameter int unsigned FRAME_CYCLES  = 50000,
    parameter int unsigned SETTLE_CYCLES = 4096,
    parameter logic [11:0] LINE_THRESH   = 12'h400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic        IR_en,
    output logic [15:0] error,
    output logic        err_vld,
    output logic        line_present
);

    localparam int unsigned FrameEff  = FAST_SIM ? FRAME_CYCLES / FAST_SIM_DIV : FRAME_CYCLES;
    localparam int unsigned SettleEff = FAST_SIM ? SETTLE_CYCLES / FAST_SIM_DIV : SETTLE_CYCLES;
    // Timer holds N-1 so the owning state lasts exactly N cycles.
    localparam logic [TIMER_W-1:0] FrameLoad  = TIMER_W'((FrameEff > 0) ? FrameEff - 1 : 0);
    localparam logic [TIMER_W-1:0] SettleLoad = TIMER_W'((SettleEff > 0) ? SettleEff - 1 : 0);

    state_t                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    any_q, any_d;
    logic [ERR_W-1:0]        error_q, error_d;
    logic                    lp_q, lp_d;
    logic                    err_vld_q, err_vld_d;
    logic                    tmr_load;
    logic [TIMER_W-1:0]      tmr_val;
    logic                    tmr_expire;

    ir_frame_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .expire_o  (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        any_d     = any_q;
        error_d   = error_q;
        lp_d      = lp_q;
        err_vld_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = SettleLoad;
        if (!go) begin
            // Abort: drop the frame, keep the last published result.
            state_d = StIdle;
            idx_d   = '0;
            acc_d   = '0;
            any_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    idx_d    = '0;
                    acc_d    = '0;
                    any_d    = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = StSettle;
                end
                StSettle: begin
                    if (tmr_expire) state_d = StConv;
                end
                StConv: state_d = StWait;
                StWait: begin
                    if (cnv_cmplt) begin
                        acc_d = acc_q + weighted(idx_q, res);
                        if (res > LINE_THRESH) any_d = 1'b1;
                        if (idx_q == 3'd7) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = StConv;
                        end
                    end
                end
                StDone: begin
                    error_d   = sat16(acc_q);
                    lp_d      = any_q;
                    err_vld_d = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = FrameLoad;
                    state_d   = StFrame;
                end
                StFrame: begin
                    idx_d = '0;
                    acc_d = '0;
                    any_d = 1'b0;
                    if (tmr_expire) begin
                        tmr_load = 1'b1;
                        state_d  = StSettle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            acc_q     <= '0;
            any_q     <= 1'b0;
            error_q   <= '0;
            lp_q      <= 1'b0;
            err_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            any_q     <= any_d;
            error_q   <= error_d;
            lp_q      <= lp_d;
            err_vld_q <= err_vld_d;
        end
    end

    assign strt_cnv     = (state_q == StConv);
    assign chnnl        = idx_q;
    assign IR_en        = (state_q == StSettle) || (state_q == StConv) || (state_q == StWait);
    assign error        = error_q;
    assign err_vld      = err_vld_q;
    assign line_present = lp_q;

endmodule

// File: tb/tb_ir_err_compute.sv
// Directed bench for ir_err_compute: vector table of frames plus reset, stall and abort sequences.
module tb_ir_err_compute;

    localparam int unsigned SETTLE = 8;
    localparam int unsigned FRAME  = 20;
    localparam int unsigned NVEC   = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        IR_en;
    logic [15:0] error;
    logic        err_vld;
    logic        line_present;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ir_err_compute #(
        .FAST_SIM     (1'b0),
        .FRAME_CYCLES (FRAME),
        .SETTLE_CYCLES(SETTLE),
        .LINE_THRESH  (12'h400)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .cnv_cmplt   (cnv_cmplt),
        .res         (res),
        .strt_cnv    (strt_cnv),
        .chnnl       (chnnl),
        .IR_en       (IR_en),
        .error       (error),
        .err_vld     (err_vld),
        .line_present(line_present)
    );

    typedef struct packed {
        logic [7:0][11:0] r;
        logic [15:0]      dly;
        logic [15:0]      err;
        logic             lp;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [11:0] a0, input logic [11:0] a1,
                                input logic [11:0] a2, input logic [11:0] a3,
                                input logic [11:0] a4, input logic [11:0] a5,
                                input logic [11:0] a6, input logic [11:0] a7,
                                input int d, input logic [15:0] e, input logic l);
        vec_t v;
        v.r[0] = a0; v.r[1] = a1; v.r[2] = a2; v.r[3] = a3;
        v.r[4] = a4; v.r[5] = a5; v.r[6] = a6; v.r[7] = a7;
        v.dly  = d[15:0];
        v.err  = e;
        v.lp   = l;
        return v;
    endfunction

    // Acts as the A2D for nch channels; returns on the negedge after the last cnv_cmplt.
    task automatic run_frame(input logic [7:0][11:0] r, input int dly, input int nch);
        for (int ch = 0; ch < nch; ch++) begin
            int n;
            bit stable;
            n = 0;
            stable = 1'b1;
            while (strt_cnv !== 1'b1 && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) begin
                total++;
                bad++;
                $display("FAIL strt_cnv_timeout: ch %0d never requested", ch);
                return;
            end
            chk("chnnl_at_strt", {29'd0, chnnl}, ch);
            chk("ir_en_at_strt", {31'd0, IR_en}, 1);
            for (int i = 0; i <= dly; i++) begin
                @(negedge clk);
                if (strt_cnv !== 1'b0 || chnnl !== ch[2:0] || IR_en !== 1'b1) stable = 1'b0;
            end
            chk("wait_stable", {31'd0, stable}, 1);
            cnv_cmplt = 1'b1;
            res       = r[ch];
            @(negedge clk);
            cnv_cmplt = 1'b0;
            res       = '0;
        end
    endtask

    // Called one cycle after the 8th cnv_cmplt was sampled.
    task automatic check_result(input string tag, input logic [15:0] e, input logic l);
        chk({tag, "_vld_early"}, {31'd0, err_vld}, 0);
        chk({tag, "_ir_en_off"}, {31'd0, IR_en}, 0);
        @(negedge clk);
        chk({tag, "_vld"}, {31'd0, err_vld}, 1);
        chk({tag, "_error"}, {16'd0, error}, {16'd0, e});
        chk({tag, "_line"}, {31'd0, line_present}, {31'd0, l});
        @(negedge clk);
        chk({tag, "_vld_pulse"}, {31'd0, err_vld}, 0);
        chk({tag, "_error_hold"}, {16'd0, error}, {16'd0, e});
    endtask

    task automatic measure_start(input string tag);
        int n;
        n  = 0;
        go = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk({tag, "_ir_en_settle"}, {31'd0, IR_en}, 1);
        end while (strt_cnv !== 1'b1 && n < 500);
        chk({tag, "_latency"}, n, SETTLE + 1);
        chk({tag, "_chnnl0"}, {29'd0, chnnl}, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;

        vecs[0] = mk(12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800,
                     0, 16'h0000, 1'b1);
        vecs[1] = mk(12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h100,
                     2, 16'h0800, 1'b0);
        vecs[2] = mk(12'h100, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
                     0, 16'hF800, 1'b0);
        vecs[3] = mk(12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
                     1, 16'h7FFF, 1'b1);
        vecs[4] = mk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000,
                     1, 16'h8000, 1'b1);
        vecs[5] = mk(12'h010, 12'h020, 12'h030, 12'h040, 12'h401, 12'h002, 12'h003, 12'h004,
                     100, 16'h0291, 1'b1);
        vecs[6] = mk(12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400,
                     1, 16'h0000, 1'b0);
        vecs[7] = mk(12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF,
                     0, 16'h7FF8, 1'b1);
        vecs[8] = mk(12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
                     0, 16'h8008, 1'b1);
        vecs[9] = mk(12'h000, 12'h000, 12'h000, 12'h401, 12'h000, 12'h000, 12'h000, 12'h000,
                     3, 16'hFBFF, 1'b1);

        rst       = 1'b1;
        go        = 1'b0;
        cnv_cmplt = 1'b0;
        res       = '0;
        repeat (2) @(negedge clk);
        chk("rst_strt_cnv", {31'd0, strt_cnv}, 0);
        chk("rst_chnnl", {29'd0, chnnl}, 0);
        chk("rst_ir_en", {31'd0, IR_en}, 0);
        chk("rst_error", {16'd0, error}, 0);
        chk("rst_err_vld", {31'd0, err_vld}, 0);
        chk("rst_line", {31'd0, line_present}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ir_en", {31'd0, IR_en}, 0);

        measure_start("first");
        for (int v = 0; v < int'(NVEC); v++) begin
            run_frame(vecs[v].r, int'(vecs[v].dly), 8);
            check_result($sformatf("vec%0d", v), vecs[v].err, vecs[v].lp);
        end

        // Reset asserted mid-frame after two conversions.
        run_frame(vecs[1].r, 0, 2);
        rst = 1'b1;
        go  = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_strt_cnv", {31'd0, strt_cnv}, 0);
        chk("midrst_chnnl", {29'd0, chnnl}, 0);
        chk("midrst_ir_en", {31'd0, IR_en}, 0);
        chk("midrst_error", {16'd0, error}, 0);
        chk("midrst_err_vld", {31'd0, err_vld}, 0);
        chk("midrst_line", {31'd0, line_present}, 0);
        rst   = 1'b0;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (strt_cnv !== 1'b0 || IR_en !== 1'b0) quiet = 1'b0;
        end
        chk("postrst_idle", {31'd0, quiet}, 1);
        measure_start("postrst");
        run_frame(vecs[1].r, 0, 8);
        check_result("postrst", 16'h0800, 1'b0);

        // Abort after the 3rd conversion; stray cnv_cmplt while idle must be ignored.
        run_frame(vecs[3].r, 0, 3);
        go = 1'b0;
        @(negedge clk);
        chk("abort_ir_en", {31'd0, IR_en}, 0);
        chk("abort_strt_cnv", {31'd0, strt_cnv}, 0);
        cnv_cmplt = 1'b1;
        res       = 12'hFFF;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        res       = '0;
        quiet     = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (err_vld !== 1'b0 || strt_cnv !== 1'b0 || IR_en !== 1'b0) quiet = 1'b0;
        end
        chk("abort_quiet", {31'd0, quiet}, 1);
        chk("abort_error_hold", {16'd0, error}, 32'h0800);
        chk("abort_line_hold", {31'd0, line_present}, 0);
        measure_start("resume");
        run_frame(vecs[2].r, 0, 8);
        check_result("resume", 16'hF800, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
